// File: rtl/wb_uart_pkg.sv
// wb_uart_pkg: shared constants and types for the Wishbone UART transmitter.
//   - register addresses on the 2-bit Wishbone address
//   - STATUS register bit positions
//   - TX engine state enum
//   - minimum clocks-per-bit and the divisor clamp helper
package wb_uart_pkg;

  localparam logic [1:0] ADDR_DIV    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RSVD   = 2'd2;
  localparam logic [1:0] ADDR_TXDATA = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic [23:0] MIN_DIV = 24'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  // A bit needs at least MIN_DIV clocks; smaller programmed values are clamped.
  function automatic logic [23:0] eff_div(input logic [23:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO, 2^FIFO_AW entries, show-ahead read.
//   i_clk, i_rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_data : write request / byte; ignored when full unless a pop
//                    happens in the same cycle
//   i_pop          : consume o_data; ignored when empty
//   o_data         : head byte (valid when !o_empty)
//   o_full, o_empty, o_count : occupancy, o_count in 0..2^FIFO_AW
module uart_tx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [7:0]       i_data,
  input  logic             i_pop,
  output logic [7:0]       o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [FIFO_AW:0] o_count
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = i_pop & ~o_empty;
  // A simultaneous pop frees the head slot, so a push into a full FIFO is legal then.
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (do_pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q] <= i_data;
  end

  assign o_data  = mem_q[rptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/wb_uart_tx_lite.sv
// wb_uart_tx_lite: Wishbone-classic slave UART transmitter (8N1, LSB first).
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_wb_cyc/stb/we    : bus cycle, strobe, write enable
//   i_wb_addr          : 0 DIV, 1 STATUS, 2 reserved, 3 TXDATA
//   i_wb_sel/i_wb_data : byte lanes / write data
//   o_wb_ack           : one-cycle ack, one cycle after acceptance
//   o_wb_stall         : always 0
//   o_wb_data          : read data, zero outside the ack cycle
//   o_uart_tx          : serial line, idle high
import wb_uart_pkg::*;

module wb_uart_tx_lite #(
  parameter int FIFO_AW     = 4,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_uart_tx
);
  // bus side
  logic        ack_q, rd_stat_q, ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d, status;
  logic [23:0] div_q, div_d;
  logic [7:0]  last_q, last_d;
  logic        req, wr, rd, push_req;
  // tx engine
  tx_state_e   state_q, state_d;
  logic [23:0] cnt_q, cnt_d, divl_q, divl_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        pop, load;
  // fifo
  logic [7:0]       f_data;
  logic             f_full, f_empty;
  logic [FIFO_AW:0] f_count;

  logic unused_bits;
  assign unused_bits = ^{i_wb_sel[3], i_wb_data[31:24]};

  // Holding stb through the ack cycle must not start a second access.
  assign req      = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr       = req & i_wb_we;
  assign rd       = req & ~i_wb_we;
  assign push_req = wr & (i_wb_addr == ADDR_TXDATA) & i_wb_sel[0];

  uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_req),
    .i_data  (i_wb_data[7:0]),
    .i_pop   (pop),
    .o_data  (f_data),
    .o_full  (f_full),
    .o_empty (f_empty),
    .o_count (f_count)
  );

  always_comb begin
    div_d = div_q;
    if (wr && i_wb_addr == ADDR_DIV)
      for (int b = 0; b < 3; b++)
        if (i_wb_sel[b]) div_d[8*b +: 8] = i_wb_data[8*b +: 8];

    last_d = last_q;
    if (push_req && (!f_full || pop)) last_d = i_wb_data[7:0];

    // Clear on the STATUS read's ack cycle; a same-cycle overflow wins.
    ovf_d = (ovf_q & ~(ack_q & rd_stat_q)) | (push_req & f_full & ~pop);

    status = '0;
    status[ST_BUSY]  = (state_q != IDLE);
    status[ST_FULL]  = f_full;
    status[ST_EMPTY] = f_empty;
    status[ST_OVF]   = ovf_q;
    status[ST_CNT_LSB +: FIFO_AW+1] = f_count;

    rdata_d = '0;
    if (rd) begin
      case (i_wb_addr)
        ADDR_DIV:    rdata_d = {8'd0, div_q};
        ADDR_STATUS: rdata_d = status;
        ADDR_RSVD:   rdata_d = '0;
        ADDR_TXDATA: rdata_d = {24'd0, last_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    divl_d  = divl_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE:  load = ~f_empty;
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          idx_d   = '0;
          cnt_d   = divl_q - 24'd1;
        end else cnt_d = cnt_q - 24'd1;
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = divl_q - 24'd1;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else cnt_d = cnt_q - 24'd1;
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (!f_empty) load    = 1'b1;
          else          state_d = IDLE;
        end else cnt_d = cnt_q - 24'd1;
      end
      default: state_d = IDLE;
    endcase
    // Frame start: the divisor is captured here so mid-frame DIV writes wait a frame.
    if (load) begin
      pop     = 1'b1;
      byte_d  = f_data;
      divl_d  = eff_div(div_q);
      cnt_d   = eff_div(div_q) - 24'd1;
      state_d = START;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ack_q     <= 1'b0;
      rd_stat_q <= 1'b0;
      rdata_q   <= '0;
      div_q     <= 24'(DEFAULT_DIV);
      last_q    <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      divl_q    <= MIN_DIV;
      idx_q     <= '0;
      byte_q    <= '0;
    end else begin
      ack_q     <= req;
      rd_stat_q <= rd & (i_wb_addr == ADDR_STATUS);
      rdata_q   <= rdata_d;
      div_q     <= div_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divl_q    <= divl_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
    end
  end

  always_comb begin
    case (state_q)
      START:   o_uart_tx = 1'b0;
      DATA:    o_uart_tx = byte_q[idx_q];
      default: o_uart_tx = 1'b1;
    endcase
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_stall = 1'b0;
  assign o_wb_data  = rdata_q;

endmodule

// File: tb/tb_wb_uart_tx_lite.sv
// tb_wb_uart_tx_lite: register-access vector table plus hand-written frame
// sequences; a serial monitor checks every line cycle of each frame against
// a scoreboard of expected {byte, divisor} entries.
module tb_wb_uart_tx_lite;
  logic        i_clk = 1'b0;
  logic        i_rst_n, cyc, stb, we;
  logic [1:0]  addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        o_wb_ack, o_wb_stall, o_uart_tx;
  logic [31:0] o_wb_data;

  wb_uart_tx_lite #(.FIFO_AW(4), .DEFAULT_DIV(434)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_sel(sel), .i_wb_data(wdata),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data), .o_uart_tx(o_uart_tx)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic we; logic [1:0] a; logic [3:0] s; logic [31:0] d; logic [31:0] exp; } vec_t;
  typedef struct { logic [7:0] b; int div; } frm_t;

  frm_t sb[$];
  int   tests = 0, fails = 0;
  int   frames_done = 0, frames_exp = 0, btb = 0;
  logic tx_at_ack, tx_after;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wb_access(input logic w, input logic [1:0] a, input logic [3:0] s,
                           input logic [31:0] d, input string nm, output logic [31:0] rdv);
    @(negedge i_clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdata = d;
    @(posedge i_clk); #1;
    check({nm, "_ack"}, {31'd0, o_wb_ack}, 32'd1);
    rdv = o_wb_data;
    tx_at_ack = o_uart_tx;
    // stb still high across this edge, as the controller holds it until it sees ack
    @(posedge i_clk); #1;
    tx_after = o_uart_tx;
    check({nm, "_ack_drop"}, {31'd0, o_wb_ack}, 32'd0);
    check({nm, "_data_idle"}, o_wb_data, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d, input string nm);
    logic [31:0] dummy;
    wb_access(1'b1, a, s, d, nm, dummy);
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] v;
    wb_access(1'b0, a, 4'hF, 32'd0, nm, v);
    check({nm, "_rdata"}, v, exp);
  endtask

  task automatic push_tx(input logic [7:0] b, input int div, input string nm);
    sb.push_back('{b: b, div: div});
    frames_exp++;
    wr(2'd3, 4'h1, {24'hFFFFFF, b}, nm);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while (frames_done != frames_exp && n < budget) begin
      @(posedge i_clk); n++;
    end
    check(nm, 32'(frames_done), 32'(frames_exp));
  endtask

  // Serial monitor: on each falling line edge pop an expected frame and compare
  // every clock of it (start, 8 data bits LSB first, stop) at div clocks per bit.
  initial begin
    bit   prev, ended_prev, ok, aborted;
    frm_t f;
    int   bad_c;
    logic exp_l, act_l, bad_e, bad_a;
    prev = 1'b1; ended_prev = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (i_rst_n === 1'b1 && prev && o_uart_tx === 1'b0) begin
        if (ended_prev) btb++;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame: line low with no byte expected (got 0 required 1)");
          ended_prev = 1'b0;
        end else begin
          f = sb.pop_front();
          ok = 1'b1; aborted = 1'b0; bad_c = -1; bad_e = 1'b0; bad_a = 1'b0;
          for (int c = 0; c < 10 * f.div; c++) begin
            if (c > 0) begin @(posedge i_clk); #1; end
            if (i_rst_n !== 1'b1) begin aborted = 1'b1; break; end
            if (c < f.div)          exp_l = 1'b0;
            else if (c >= 9*f.div)  exp_l = 1'b1;
            else                    exp_l = f.b[c / f.div - 1];
            act_l = o_uart_tx;
            if (ok && act_l !== exp_l) begin ok = 1'b0; bad_c = c; bad_e = exp_l; bad_a = act_l; end
          end
          if (!aborted) begin
            tests++;
            if (!ok) begin
              fails++;
              $display("FAIL frame_%02h: line at cycle %0d of frame got %b required %b (div %0d)",
                       f.b, bad_c, bad_a, bad_e, f.div);
            end
            frames_done++;
          end
          ended_prev = !aborted;
          prev = 1'b1;
          continue;
        end
      end else ended_prev = 1'b0;
      prev = o_uart_tx;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached (got timeout required finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[17];
    logic [31:0] v;
    vecs[0]  = '{1'b0, 2'd1, 4'hF, 32'h0,        32'h0000_0004};
    vecs[1]  = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h0000_01B2};
    vecs[2]  = '{1'b1, 2'd0, 4'h7, 32'h00AB_CDEF, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h00AB_CDEF};
    vecs[4]  = '{1'b1, 2'd0, 4'h1, 32'hFFFF_FF12, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h00AB_CD12};
    vecs[6]  = '{1'b1, 2'd0, 4'h8, 32'h5500_0000, 32'h0};
    vecs[7]  = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h00AB_CD12};
    vecs[8]  = '{1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 4'hF, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 2'd1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b0, 2'd1, 4'hF, 32'h0,        32'h0000_0004};
    vecs[12] = '{1'b1, 2'd3, 4'hE, 32'h0000_00AA, 32'h0};
    vecs[13] = '{1'b0, 2'd1, 4'hF, 32'h0,        32'h0000_0004};
    vecs[14] = '{1'b0, 2'd3, 4'hF, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 2'd0, 4'hF, 32'h0000_01B2, 32'h0};
    vecs[16] = '{1'b0, 2'd0, 4'hF, 32'h0,        32'h0000_01B2};

    i_rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_ack",   {31'd0, o_wb_ack},   32'd0);
    check("reset_data",  o_wb_data,           32'd0);
    check("reset_tx",    {31'd0, o_uart_tx},  32'd1);
    check("stall_tied0", {31'd0, o_wb_stall}, 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      wb_access(vecs[i].we, vecs[i].a, vecs[i].s, vecs[i].d, $sformatf("vec%0d", i), v);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), v, vecs[i].exp);
    end

    // controller-style write of 'f' at 434 clocks per bit
    wr(2'd0, 4'h7, 32'd434, "div434");
    sb.push_back('{b: 8'h66, div: 434}); frames_exp++;
    wr(2'd3, 4'h1, 32'h0000_0066, "tx66");
    check("tx66_line_at_ack",  {31'd0, tx_at_ack}, 32'd1);
    check("tx66_line_fall_n2", {31'd0, tx_after},  32'd0);
    repeat (4338) @(posedge i_clk);
    rd_chk(2'd1, 32'h0000_0005, "busy_last_cycle");
    rd_chk(2'd1, 32'h0000_0004, "busy_cleared");
    rd_chk(2'd3, 32'h0000_0066, "last_pushed");
    wait_drain(100, "drain_66");

    // 17 quick bytes at div=4: one pops at once, 16 fill the FIFO
    wr(2'd0, 4'h7, 32'd4, "div4");
    for (int i = 0; i < 17; i++) push_tx(8'hA0 + 8'(i*7), 4, $sformatf("burst%0d", i));
    btb = 0;
    rd_chk(2'd1, 32'h0000_1003, "status_full");
    wr(2'd3, 4'h1, 32'h0000_00EE, "overflow_push");
    rd_chk(2'd1, 32'h0000_100B, "status_ovf");
    rd_chk(2'd1, 32'h0000_1003, "status_ovf_cleared");
    wait_drain(17*40 + 100, "drain_burst");
    check("burst_back_to_back", 32'(btb), 32'd16);
    rd_chk(2'd1, 32'h0000_0004, "burst_empty");

    // DIV=0 written mid-frame: current frame keeps 4, next one clamps to 2
    push_tx(8'h5A, 4, "mid_a");
    push_tx(8'hC3, 2, "mid_b");
    wr(2'd0, 4'h7, 32'd0, "div0");
    wait_drain(200, "drain_div0");
    rd_chk(2'd0, 32'h0000_0000, "div0_readback");

    // reset in the middle of the DATA bits, with a second byte still queued
    wr(2'd0, 4'h7, 32'd300, "div300");
    push_tx(8'h00, 300, "rst_a");
    push_tx(8'h11, 300, "rst_b");
    repeat (300*3) @(posedge i_clk);
    @(negedge i_clk);
    check("pre_reset_line", {31'd0, o_uart_tx}, 32'd0);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    check("reset_line_high", {31'd0, o_uart_tx}, 32'd1);
    repeat (2) @(posedge i_clk);
    sb.delete();
    frames_exp = frames_done;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    rd_chk(2'd1, 32'h0000_0004, "post_reset_status");
    rd_chk(2'd0, 32'h0000_01B2, "post_reset_div");
    repeat (700) @(posedge i_clk);
    #1;
    check("post_reset_idle_line", {31'd0, o_uart_tx}, 32'd1);
    check("post_reset_no_frames", 32'(frames_done), 32'(frames_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx_lite.md
# wb_uart_tx_lite

Wishbone-classic slave UART transmitter sitting directly downstream of the push-button Wishbone controller. It decodes the controller's single-beat writes to a baud-divisor register (address 0) and a transmit-data register (address 3). It buffers bytes in a small FIFO and serialises them 8N1, LSB first, onto `o_uart_tx`. A status register lets a master poll busy, FIFO level and overflow.

## Interface
Parameters:
- `FIFO_AW`, 4: FIFO address width; the FIFO holds 2^FIFO_AW bytes.
- `DEFAULT_DIV`, 434: reset value of the clocks-per-bit divisor (50 MHz / 115200).

Ports:
- `i_clk` in 1: sole clock.
- `i_rst_n` in 1: reset, synchronous and active-low.
- `i_wb_cyc` in 1: bus cycle.
- `i_wb_stb` in 1: strobe.
- `i_wb_we` in 1: write enable.
- `i_wb_addr` in 2: register select.
- `i_wb_sel` in 4: byte lanes.
- `i_wb_data` in 32: write data.
- `o_wb_ack` out 1: single-cycle acknowledge.
- `o_wb_stall` out 1: tied 0.
- `o_wb_data` out 32: read data, valid with ack.
- `o_uart_tx` out 1: serial line, idle high.

## Operation
Request handling:
- A request is accepted when `i_wb_cyc & i_wb_stb & !o_wb_ack`.
- Every accepted request is acked exactly once, one cycle later.
- A strobe held high during the ack cycle is not a new request. This makes the controller's hold-until-ack handshake produce exactly one access.

Register map:
- Addr 0, DIV, R/W: bits [23:0] are the divisor; `i_wb_sel[2:0]` gate the byte writes. Reads return {8'd0, div}.
- Addr 1, STATUS, RO: bit0 tx_busy, bit1 full, bit2 empty, bit3 overflow (sticky), [FIFO_AW+8:8] count. A read clears overflow in the ack cycle. Writes are acked and ignored.
- Addr 2: reads 0; writes are ignored and acked.
- Addr 3, TXDATA: a write with `i_wb_sel[0]=1` pushes `i_wb_data[7:0]`. If the FIFO is full, the byte is dropped and overflow is set. Reads return the last pushed byte, zero-extended.

TX engine states:
- IDLE: `o_uart_tx`=1. If the FIFO is not empty, pop, latch the byte, latch the divisor and go to START.
- START: line 0 for div clocks, then DATA with bit index 0.
- DATA: line = byte[idx] for div clocks each; after idx 7, go to STOP.
- STOP: line 1 for div clocks. Then go to START if the FIFO is not empty (popped in the same cycle), else IDLE.

Divisor rules:
- The divisor is sampled only at frame start; writes during a frame affect the next frame.
- An effective divisor value below 2 is treated as 2.
- The bit counter is 24 bits and counts down from div-1 to 0.

Status definitions:
- tx_busy = (state != IDLE).
- count is 0..2^FIFO_AW.

## Timing
Reset values:
- `o_uart_tx`=1, `o_wb_ack`=0, `o_wb_data`=0.
- div=DEFAULT_DIV, FIFO empty, overflow=0, state IDLE.

Write and frame latency:
- A TXDATA write accepted at cycle N is acked at N+1, and the FIFO shows non-empty at N+1.
- With an idle engine, `o_uart_tx` falls at N+2.
- A frame is exactly 10·div clocks, and back-to-back frames have no idle gap.

Boundary cases:
- A push and a pop in the same cycle leave count unchanged; this is legal even when full, since the pop frees the slot first.
- A push when full with no pop is dropped and sets overflow.
- A STATUS read that coincides with an overflow event leaves overflow = 1 (set wins).
- Pointers wrap modulo 2^FIFO_AW.
- Reset asserted mid-frame drives the line high on the next clock and discards FIFO contents.
- `o_wb_data` is 0 whenever `o_wb_ack`=0.

## Structure
- Package `wb_uart_pkg` holds:
  - register address constants (ADDR_DIV=0, ADDR_STATUS=1, ADDR_TXDATA=3);
  - STATUS bit positions;
  - the TX state enum (IDLE, START, DATA, STOP);
  - the minimum-divisor constant.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with push/pop, full/empty and count, parameterised by FIFO_AW.
- Bus decode, registers and the TX engine stay in the top module.

## Test plan
- Reset, then read STATUS: ack 1 cycle after strobe, data = 0x00000004 (empty), `o_uart_tx`=1.
- Controller sequence: write DIV=434, then TXDATA=0x66 ('f') with stb held until ack.
  - Exactly one push.
  - Line low at N+2, bits 0,1,1,0,0,1,1,0 at 434 clocks each, then stop bit.
  - tx_busy clears after 4340 clocks.
- Set div=4 and write 17 bytes quickly with FIFO_AW=4.
  - The first byte pops immediately; the remaining 16 fill the FIFO.
  - STATUS shows full and count 16, with overflow 0. Then write one more: overflow=1.
  - Read STATUS clears overflow; all 17 frames go out back-to-back at 40 clocks each.
- Write DIV=0 mid-frame: the current frame keeps the old div, and the next frame uses 2 clocks per bit.
- Assert reset mid-DATA: line high next clock, STATUS reads empty, div=434.
